// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port synchronous memory between fetch and data requesters
// Data has priority; a pending fetch is admitted after at most MAX_DSTREAK consecutive data grants.
module mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MEM_LAT     = 1,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    state_t          r_state;
    state_t          w_next;
    logic            r_owner;
    logic            r_store;
    logic [3:0]      r_streak;
    logic [2:0]      r_cnt;
    logic            r_mem_en;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            r_if_ack;
    logic            r_d_ack;
    logic            w_grant_d;
    logic            w_grant_i;
    logic            w_last;

    always_comb begin
        w_next    = r_state;
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        w_last    = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_req && (!if_req || (r_streak < STREAK_MAX))) begin
                    w_grant_d = 1'b1;
                    w_next    = ISSUE;
                end else if (if_req) begin
                    w_grant_i = 1'b1;
                    w_next    = ISSUE;
                end
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                w_last = (r_cnt == 3'd1);
                if (w_last) w_next = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner     <= 1'b0;
            r_store     <= 1'b0;
            r_streak    <= '0;
            r_cnt       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            if (w_grant_d || w_grant_i) begin
                r_owner     <= w_grant_d;
                r_store     <= w_grant_d & d_we;
                r_mem_en    <= 1'b1;
                r_mem_we    <= w_grant_d & d_we;
                r_mem_addr  <= w_grant_d ? d_addr : if_addr;
                r_mem_wdata <= w_grant_d ? d_wdata : '0;
            end
            // A data grant with fetch pending implies streak < max, so this saturates by construction.
            if (w_grant_d && if_req) r_streak <= r_streak + 4'd1;
            if (w_grant_i)           r_streak <= '0;
            if (r_state == ISSUE) begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
                r_cnt    <= LAT_INIT;
            end
            if (r_state == WAIT) r_cnt <= r_cnt - 3'd1;
            if (w_last) begin
                if (!r_owner)      r_if_rdata <= mem_rdata;
                else if (!r_store) r_d_rdata  <= mem_rdata;
                r_if_ack <= ~r_owner;
                r_d_ack  <= r_owner;
            end
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ack    = r_if_ack;
    assign d_rdata   = r_d_rdata;
    assign d_ack     = r_d_ack;
    assign stall_if  = if_req & ~r_if_ack;
    assign stall_mem = d_req & ~r_d_ack;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter against a transaction-timeline model
module tb_mem_arbiter;
    localparam int LAT  = 1;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, d_ack, stall_if, stall_mem, mem_en, mem_we;

    logic        l3_if_req, l3_d_req, l3_d_we;
    logic [31:0] l3_if_addr, l3_d_addr, l3_d_wdata;
    logic [31:0] l3_if_rdata, l3_d_rdata, l3_mem_addr, l3_mem_wdata, l3_mem_rdata;
    logic        l3_if_ack, l3_d_ack, l3_stall_if, l3_stall_mem, l3_mem_en, l3_mem_we;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .MAX_DSTREAK(MAXS)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_DSTREAK(MAXS)) u_lat3 (
        .clk(clk), .reset(reset),
        .if_req(l3_if_req), .if_addr(l3_if_addr), .if_rdata(l3_if_rdata), .if_ack(l3_if_ack),
        .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata),
        .d_rdata(l3_d_rdata), .d_ack(l3_d_ack), .stall_if(l3_stall_if), .stall_mem(l3_stall_mem),
        .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
        .mem_rdata(l3_mem_rdata)
    );

    // Environment memories; non-valid read cycles return noise so capture timing matters.
    logic [31:0] env_mem [0:127];
    logic [31:0] ref_mem [0:127];
    logic [31:0] rd_pipe;
    logic [31:0] env3_mem [0:3];
    logic [31:0] rd3 [0:2];

    always @(posedge clk) begin
        if (mem_en && mem_we) env_mem[mem_addr[8:2]] <= mem_wdata;
        rd_pipe <= (mem_en && !mem_we) ? env_mem[mem_addr[8:2]] : $urandom;
        rd3[0]  <= (l3_mem_en && !l3_mem_we) ? env3_mem[l3_mem_addr[3:2]] : $urandom;
        rd3[1]  <= rd3[0];
        rd3[2]  <= rd3[1];
    end
    assign mem_rdata    = rd_pipe;
    assign l3_mem_rdata = rd3[2];

    typedef struct {
        int          cyc;
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        iss_q[$];
    txn_t        ack_q[$];
    bit          ack_log[$];
    int          cyc = 0;
    int          m_free = 0;
    int          m_streak = 0;
    logic [31:0] last_i = '0, last_d = '0;
    int          vecs = 0, errs = 0;
    bit          f_on = 0, d_on = 0;
    int          gap_max = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name);
        vecs++;
        errs++;
        $display("FAIL %s: got timeout expected completion (cycle %0d)", name, cyc);
    endtask

    // Reference model: each grant occupies the memory for LAT+3 cycles; decisions follow the priority rule.
    always @(posedge clk) begin
        txn_t t;
        bit   gd, gi;
        if (!reset) begin
            m_streak = 0;
            m_free   = cyc + 1;
        end else if (cyc >= m_free) begin
            gd = d_req && (!if_req || m_streak < MAXS);
            gi = !gd && if_req;
            if (gd || gi) begin
                t.is_d  = gd;
                t.we    = gd && d_we;
                t.addr  = gd ? d_addr : if_addr;
                t.wdata = d_wdata;
                t.rdata = ref_mem[t.addr[8:2]];
                if (gd) begin
                    if (if_req) m_streak++;
                    if (t.we) ref_mem[t.addr[8:2]] = t.wdata;
                end else begin
                    m_streak = 0;
                end
                t.cyc = cyc + 1;
                iss_q.push_back(t);
                t.cyc = cyc + 2 + LAT;
                ack_q.push_back(t);
                m_free = cyc + LAT + 3;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        txn_t t;
        bit   exp_ia, exp_da, exp_en, exp_we;
        logic [31:0] exp_addr, exp_wdata;
        exp_ia = 0; exp_da = 0; exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
        if (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
            void'(ack_q.pop_front());
            bad("ack_missing");
        end
        if (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
            void'(iss_q.pop_front());
            bad("issue_missing");
        end
        if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
            t = ack_q.pop_front();
            if (t.is_d) begin
                exp_da = 1;
                if (!t.we) last_d = t.rdata;
            end else begin
                exp_ia = 1;
                last_i = t.rdata;
            end
        end
        if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
            t = iss_q.pop_front();
            exp_en = 1; exp_we = t.we; exp_addr = t.addr; exp_wdata = t.wdata;
        end
        if (!reset) begin
            last_i = '0;
            last_d = '0;
            chk("rst_mem_addr", mem_addr, '0);
            chk("rst_mem_wdata", mem_wdata, '0);
        end
        chk("if_ack", {31'b0, if_ack}, {31'b0, exp_ia});
        chk("d_ack", {31'b0, d_ack}, {31'b0, exp_da});
        chk("mem_en", {31'b0, mem_en}, {31'b0, exp_en});
        chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        if (exp_en) chk("mem_addr", mem_addr, exp_addr);
        if (exp_en && exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
        chk("if_rdata", if_rdata, last_i);
        chk("d_rdata", d_rdata, last_d);
        chk("stall_if", {31'b0, stall_if}, {31'b0, if_req & ~exp_ia});
        chk("stall_mem", {31'b0, stall_mem}, {31'b0, d_req & ~exp_da});
        if (if_ack) ack_log.push_back(1'b0);
        if (d_ack)  ack_log.push_back(1'b1);
    end

    initial begin : fetch_drv
        @(posedge clk); #1;
        forever begin
            if (f_on) begin
                bit got;
                if_req  = 1'b1;
                if_addr = {23'b0, 7'($urandom_range(0, 127)), 2'b00};
                got = 0;
                for (int k = 0; k < 300; k++) begin
                    @(negedge clk);
                    if (if_ack) begin got = 1; break; end
                end
                if (!got) bad("fetch_drv_timeout");
                @(posedge clk); #1;
                if (!f_on || $urandom_range(0, gap_max) != 0) begin
                    if_req = 1'b0;
                    @(posedge clk); #1;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    initial begin : data_drv
        @(posedge clk); #1;
        forever begin
            if (d_on) begin
                bit got;
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = {23'b0, 7'($urandom_range(0, 127)), 2'b00};
                d_wdata = $urandom;
                got = 0;
                for (int k = 0; k < 300; k++) begin
                    @(negedge clk);
                    if (d_ack) begin got = 1; break; end
                end
                if (!got) bad("data_drv_timeout");
                @(posedge clk); #1;
                if (!d_on || $urandom_range(0, gap_max) != 0) begin
                    d_req = 1'b0;
                    @(posedge clk); #1;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    task automatic run_req(input bit is_d, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, output int lat);
        if (is_d) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
        else      begin if_req = 1; if_addr = a; end
        lat = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (is_d ? d_ack : if_ack) begin lat = k; break; end
        end
        @(posedge clk); #1;
        if (is_d) d_req = 0; else if_req = 0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!if_req && !d_req && ack_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) bad("idle_timeout");
        @(posedge clk); #1;
    endtask

    initial begin : main
        int lat, en_k;
        bit pat [10];
        logic [31:0] v;
        pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 128; i++) begin
            v = $urandom;
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        env_mem[16] = 32'h8C010004;
        ref_mem[16] = 32'h8C010004;
        for (int i = 0; i < 4; i++) env3_mem[i] = 32'h13579BDF + i;
        reset = 1;
        if_req = 0; if_addr = 32'h40; d_req = 0; d_we = 0; d_addr = 32'h80; d_wdata = 0;
        l3_if_req = 0; l3_if_addr = 0; l3_d_req = 0; l3_d_we = 0; l3_d_addr = 0; l3_d_wdata = 0;
        #2;
        reset = 0; if_req = 1; d_req = 1;
        repeat (3) @(posedge clk);
        #1;
        if_req = 0; d_req = 0; reset = 1;
        @(posedge clk); #1;

        run_req(0, 0, 32'h40, 0, lat);
        chk("fetch_latency", 32'(lat), 32'(LAT + 2));
        chk("fetch_data", if_rdata, 32'h8C010004);

        run_req(1, 1, 32'h100, 32'hDEADBEEF, lat);
        chk("store_latency", 32'(lat), 32'(LAT + 2));
        run_req(1, 0, 32'h100, 0, lat);
        chk("load_latency", 32'(lat), 32'(LAT + 2));
        chk("load_data", d_rdata, 32'hDEADBEEF);

        @(negedge clk);
        ack_log.delete();
        gap_max = 0; f_on = 1; d_on = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ack_log.size() >= 10) break;
        end
        f_on = 0; d_on = 0;
        if (ack_log.size() < 10) bad("priority_timeout");
        else for (int i = 0; i < 10; i++) chk($sformatf("grant_order[%0d]", i),
                                               {31'b0, ack_log[i]}, {31'b0, pat[i]});
        wait_idle();

        @(negedge clk);
        gap_max = 2; f_on = 1; d_on = 1;
        repeat (400) @(negedge clk);
        f_on = 0; d_on = 0;
        wait_idle();

        d_we = 0; d_addr = 32'h40; d_req = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        iss_q.delete();
        ack_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        lat = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (d_ack) begin lat = k; break; end
        end
        chk("reset_regrant_latency", 32'(lat), 32'd3);
        @(posedge clk); #1;
        d_req = 0;
        wait_idle();

        l3_d_we = 0; l3_d_addr = 32'h4; l3_d_req = 1;
        lat = -1; en_k = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (l3_mem_en && en_k < 0) en_k = k;
            if (l3_d_ack) begin lat = k; break; end
        end
        chk("lat3_issue_cycle", 32'(en_k), 32'd1);
        chk("lat3_ack_latency", 32'(lat), 32'd5);
        chk("lat3_data", l3_d_rdata, 32'h13579BE0);
        @(posedge clk); #1;
        l3_d_req = 0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
